// File: rtl/i2s_tx_master.sv
// I2S / left-justified master transmitter: SCK and WS generation, a stereo
// sample FIFO with valid/ready input, and a frame shift register feeding sd_out.
module i2s_tx_master #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               mode,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [2*DATA_W-1:0]                s_data,
  input  logic                               underrun_clr,
  output logic                               underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               busy,
  output logic                               SCK,
  output logic                               WS,
  output logic                               sd_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = 2 * SLOT_W;
  localparam int CW = $clog2(FW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);
  localparam logic [CW-1:0] SLOT_BIT = CW'(SLOT_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          ws_q, ws_d;
  logic          sd_q, sd_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          underrun_q, underrun_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic          push, pop, load;
  logic [CW-1:0] nxt_cnt;
  logic [FW-1:0] frame_word;

  assign s_ready = reset && (level_q != FULL_LVL);
  assign push    = s_valid && s_ready;
  assign nxt_cnt = bit_cnt_q + CW'(1);

  // An empty FIFO yields a silent frame rather than stale data.
  always_comb begin
    frame_word = '0;
    if (level_q != '0) begin
      frame_word[FW-1 -: DATA_W]     = mem[rd_ptr_q][2*DATA_W-1 -: DATA_W];
      frame_word[SLOT_W-1 -: DATA_W] = mem[rd_ptr_q][DATA_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        div_d     = '0;
        sck_d     = 1'b0;
        ws_d      = 1'b0;
        sd_d      = 1'b0;
        bit_cnt_d = '0;
        busy_d    = 1'b0;
        if (enable) begin
          state_d = RUN;
          mode_d  = mode;
          busy_d  = 1'b1;
          load    = 1'b1;
          shift_d = frame_word;
          sd_d    = mode ? frame_word[FW-1] : 1'b0;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = !sck_q;
          if (sck_q) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              ws_d      = 1'b0;
              if (!enable) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sd_d    = 1'b0;
              end else begin
                load    = 1'b1;
                shift_d = frame_word;
                // I2S: the previous frame's last bit spills into this first SCK.
                sd_d    = mode_q ? frame_word[FW-1] : shift_q[FW-1];
              end
            end else begin
              bit_cnt_d = nxt_cnt;
              ws_d      = (nxt_cnt >= SLOT_BIT);
              shift_d   = {shift_q[FW-2:0], 1'b0};
              sd_d      = mode_q ? shift_q[FW-2] : shift_q[FW-1];
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pop        = load && (level_q != '0);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + LW'(push) - LW'(pop);
    underrun_d = (load && (level_q == '0)) ? 1'b1 :
                 (underrun_clr ? 1'b0 : underrun_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      div_q      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  assign busy       = busy_q;
  assign SCK        = sck_q;
  assign WS         = ws_q;
  assign sd_out     = sd_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: default build (A) plus a 24/24/div-1 build (B).
module tb_i2s_tx_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        en_a, mode_a, sv_a, sr_a, clr_a, ur_a, busy_a, sck_a, ws_a, sd_a;
  logic [31:0] sdata_a;
  logic [2:0]  lvl_a;

  logic        en_b, mode_b, sv_b, sr_b, clr_b, ur_b, busy_b, sck_b, ws_b, sd_b;
  logic [47:0] sdata_b;
  logic [1:0]  lvl_b;

  int checks = 0;
  int errors = 0;

  i2s_tx_master dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .mode(mode_a),
    .s_valid(sv_a), .s_ready(sr_a), .s_data(sdata_a),
    .underrun_clr(clr_a), .underrun(ur_a), .fifo_level(lvl_a),
    .busy(busy_a), .SCK(sck_a), .WS(ws_a), .sd_out(sd_a)
  );

  i2s_tx_master #(.DATA_W(24), .SLOT_W(24), .CLK_DIV(1), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .mode(mode_b),
    .s_valid(sv_b), .s_ready(sr_b), .s_data(sdata_b),
    .underrun_clr(clr_b), .underrun(ur_b), .fifo_level(lvl_b),
    .busy(busy_b), .SCK(sck_b), .WS(ws_b), .sd_out(sd_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame16(input logic [31:0] p);
    return {p[31:16], 16'h0, p[15:0], 16'h0};
  endfunction

  // Collect sd/WS at each SCK rising edge (what a receiver samples).
  task automatic capture(input bit sel_b, input int nbits,
                         output logic [63:0] sdv, output logic [63:0] wsv,
                         output int lat, output int per);
    int cyc, last, guard;
    logic prev, s;
    cyc = 0; last = 0; lat = 0; per = 0; sdv = '0; wsv = '0;
    for (int k = 0; k < nbits; k++) begin
      guard = 0;
      do begin
        prev = sel_b ? sck_b : sck_a;
        @(negedge clk);
        cyc++;
        guard++;
        s = sel_b ? sck_b : sck_a;
      end while (!(!prev && s) && guard < 200);
      if (guard >= 200) begin
        check_eq("sck_timeout", 64'(guard), 64'(0));
        return;
      end
      if (k == 0) lat = cyc;
      if (k == 1) per = cyc - last;
      last = cyc;
      sdv = {sdv[62:0], (sel_b ? sd_b : sd_a)};
      wsv = {wsv[62:0], (sel_b ? ws_b : ws_a)};
    end
  endtask

  task automatic push_a(input logic [31:0] d);
    sdata_a = d; sv_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0;
  endtask

  task automatic push_b(input logic [47:0] d);
    sdata_b = d; sv_b = 1'b1;
    @(negedge clk);
    sv_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] WS_A = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] WS_B = 64'h00000000_00FFFFFF;

  initial begin
    logic [31:0] pairs [6];
    logic [63:0] sdv, wsv, v1, v2, w1, w2, expv;
    logic [47:0] g0, g1;
    int lat, per;

    pairs[0] = {16'hA5C3, 16'h0F01};
    pairs[1] = {16'h1234, 16'h8001};
    pairs[2] = {16'hFFFF, 16'h0000};
    pairs[3] = {16'h0001, 16'h8000};
    pairs[4] = {16'hDEAD, 16'hBEEF};
    pairs[5] = {16'hCAFE, 16'hF00D};
    g0 = {24'hC00001, 24'h800001};
    g1 = {24'h5A5A5A, 24'h000003};

    reset = 1'b0;
    en_a = 0; mode_a = 1; sv_a = 0; sdata_a = '0; clr_a = 0;
    en_b = 0; mode_b = 0; sv_b = 0; sdata_b = '0; clr_b = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_lines_a", 64'({sck_a, ws_a, sd_a}), 64'(0));
    check_eq("rst_flags_a", 64'({busy_a, ur_a, sr_a}), 64'(0));
    check_eq("rst_level_a", 64'(lvl_a), 64'(0));
    check_eq("rst_all_b", 64'({sck_b, ws_b, sd_b, busy_b, ur_b, sr_b, lvl_b}), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 64'(sr_a), 64'(1));

    // Backpressure: six offered, four accepted.
    for (int i = 0; i < 6; i++) begin
      sdata_a = pairs[i]; sv_a = 1'b1;
      @(negedge clk);
    end
    sv_a = 1'b0;
    $display("fill: level=%0d ready=%0b", lvl_a, sr_a);
    check_eq("full_level", 64'(lvl_a), 64'(4));
    check_eq("full_ready", 64'(sr_a), 64'(0));

    // Left-justified.
    mode_a = 1; en_a = 1;
    capture(0, 64, sdv, wsv, lat, per);
    $display("lj frame1: sd=%h ws=%h lat=%0d per=%0d", sdv, wsv, lat, per);
    check_eq("lj_first_rise", 64'(lat), 64'(3));
    check_eq("lj_period", 64'(per), 64'(4));
    check_eq("lj_ws", wsv, WS_A);
    check_eq("lj_data", sdv, frame16(pairs[0]));
    check_eq("run_busy", 64'(busy_a), 64'(1));
    check_eq("pop_level", 64'(lvl_a), 64'(3));
    check_eq("pop_ready", 64'(sr_a), 64'(1));

    mode_a = 0;
    capture(0, 64, sdv, wsv, lat, per);
    $display("lj frame2: sd=%h", sdv);
    check_eq("mode_ignored_order", sdv, frame16(pairs[1]));

    capture(0, 20, v1, w1, lat, per);
    en_a = 0;
    capture(0, 44, v2, w2, lat, per);
    sdv = {v1[19:0], v2[43:0]};
    $display("lj frame3: sd=%h", sdv);
    check_eq("stop_frame_complete", sdv, frame16(pairs[2]));
    check_eq("busy_last_bit", 64'(busy_a), 64'(1));
    repeat (2) @(negedge clk);
    check_eq("stop_busy", 64'(busy_a), 64'(0));
    check_eq("stop_lines", 64'({sck_a, ws_a, sd_a}), 64'(0));
    check_eq("stop_level", 64'(lvl_a), 64'(1));

    // I2S: queued pairs[3], then A5C3/0F01.
    push_a(pairs[0]);
    check_eq("requeue_level", 64'(lvl_a), 64'(2));
    mode_a = 0; en_a = 1;
    capture(0, 64, sdv, wsv, lat, per);
    $display("i2s frame1: sd=%h ws=%h", sdv, wsv);
    check_eq("i2s_first_rise", 64'(lat), 64'(3));
    check_eq("i2s_ws", wsv, WS_A);
    check_eq("i2s_frame1", sdv, frame16(pairs[3]) >> 1);
    capture(0, 64, sdv, wsv, lat, per);
    $display("i2s frame2: sd=%h", sdv);
    v1 = frame16(pairs[3]);
    v2 = frame16(pairs[0]);
    expv = {v1[0], v2[63:1]};
    check_eq("i2s_frame2", sdv, expv);
    check_eq("i2s_msb_2nd_rise", 64'(sdv[62]), 64'(1));
    check_eq("no_underrun_yet", 64'(ur_a), 64'(0));

    // Underrun.
    repeat (2) @(negedge clk);
    check_eq("underrun_set", 64'(ur_a), 64'(1));
    check_eq("underrun_level", 64'(lvl_a), 64'(0));
    clr_a = 1;
    @(negedge clk);
    clr_a = 0;
    check_eq("underrun_clr", 64'(ur_a), 64'(0));
    capture(0, 64, sdv, wsv, lat, per);
    $display("underrun frame: sd=%h", sdv);
    check_eq("underrun_zeros", sdv, 64'(0));
    @(negedge clk);
    clr_a = 1;
    @(negedge clk);
    clr_a = 0;
    en_a = 0;
    check_eq("underrun_set_beats_clr", 64'(ur_a), 64'(1));
    capture(0, 64, sdv, wsv, lat, per);
    repeat (2) @(negedge clk);
    check_eq("stop2_busy", 64'(busy_a), 64'(0));

    // Reset in the right slot.
    push_a(pairs[1]);
    push_a(pairs[2]);
    mode_a = 1; en_a = 1;
    capture(0, 40, sdv, wsv, lat, per);
    check_eq("in_right_slot", 64'(ws_a), 64'(1));
    reset = 1'b0;
    #1;
    $display("mid-frame reset: sck=%0b ws=%0b sd=%0b level=%0d", sck_a, ws_a, sd_a, lvl_a);
    check_eq("midrst_lines", 64'({sck_a, ws_a, sd_a}), 64'(0));
    check_eq("midrst_level", 64'(lvl_a), 64'(0));
    check_eq("midrst_flags", 64'({busy_a, ur_a}), 64'(0));
    en_a = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_a(pairs[0]);
    mode_a = 1; en_a = 1;
    capture(0, 64, sdv, wsv, lat, per);
    $display("post-reset frame: sd=%h ws=%h", sdv, wsv);
    check_eq("postrst_lat", 64'(lat), 64'(3));
    check_eq("postrst_ws", wsv, WS_A);
    check_eq("postrst_data", sdv, frame16(pairs[0]));
    check_eq("postrst_underrun", 64'(ur_a), 64'(0));
    en_a = 0;
    repeat (2) @(negedge clk);
    check_eq("postrst_stop", 64'(busy_a), 64'(0));

    // Build B: full-width slots, fastest SCK, I2S.
    push_b(g0);
    push_b(g1);
    check_eq("b_full", 64'({sr_b, lvl_b}), 64'({1'b0, 2'd2}));
    mode_b = 0; en_b = 1;
    capture(1, 48, sdv, wsv, lat, per);
    $display("b frame1: sd=%h ws=%h lat=%0d per=%0d", sdv, wsv, lat, per);
    check_eq("b_first_rise", 64'(lat), 64'(2));
    check_eq("b_period", 64'(per), 64'(2));
    check_eq("b_ws", wsv, WS_B);
    check_eq("b_frame1", sdv, 64'({1'b0, g0[47:1]}));
    capture(1, 10, v1, w1, lat, per);
    en_b = 0;
    capture(1, 38, v2, w2, lat, per);
    sdv = 64'({v1[9:0], v2[37:0]});
    $display("b frame2: sd=%h", sdv);
    check_eq("b_frame2", sdv, 64'({g0[0], g1[47:1]}));
    check_eq("b_carry_lsb", 64'(sdv[47]), 64'(1));
    @(negedge clk);
    check_eq("b_stop_busy", 64'(busy_b), 64'(0));
    check_eq("b_no_trailing_bit", 64'({sck_b, ws_b, sd_b}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
- Parametrised I2S master transmitter: generates SCK and WS, and serialises buffered stereo samples onto sd_out.
- Successor to the fixed-format I2S link. Adds the following:
  - configurable sample and slot width
  - programmable SCK divider
  - I2S or left-justified framing
  - input FIFO with valid/ready handshake
  - sticky underrun flag
- Sits between the audio sample source and the pad-level i2s bus (sd_out, WS, SCK).

Parameters:
- DATA_W, 16, sample width per channel; legal range 1 to SLOT_W.
- SLOT_W, 32, SCK cycles per channel slot; frame length is 2*SLOT_W SCK cycles.
- CLK_DIV, 2, clk cycles per SCK half-period; minimum 1.
- FIFO_DEPTH, 4, stereo frames buffered; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  run request
- mode  input  1  0 = I2S (1-SCK data delay after WS edge), 1 = left-justified
- s_valid  input  1  sample pair valid
- s_ready  output  1  FIFO can accept a pair
- s_data  input  2*DATA_W  {left, right}; left is the upper half
- underrun_clr  input  1  clears the underrun flag
- underrun  output  1  sticky: a frame started with the FIFO empty
- fifo_level  output  $clog2(FIFO_DEPTH+1)  frames currently buffered
- busy  output  1  high in RUN state
- SCK  output  1  serial clock
- WS  output  1  word select; 0 = left, 1 = right
- sd_out  output  1  serial data, MSB first

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, state IDLE.
  - SCK=0, WS=0, sd_out=0, underrun=0, busy=0, fifo_level=0, s_ready=0 while reset is held.
  - Applies mid-frame with no graceful completion.
- FIFO:
  - s_ready = !full.
  - Push when s_valid && s_ready.
  - Pop only at frame start.
  - Push and pop in the same cycle: level unchanged.
  - Pop on an empty FIFO in the same cycle as a push: the pushed pair is stored, and the frame sends zeros.
- States:
  - IDLE to RUN: on enable=1.
  - Entry cycle actions: latch mode, bit_cnt=0, SCK=0, WS=0, load frame, busy=1.
  - RUN to IDLE: enable=0 seen at any time stops the block at the end of the current frame, at the falling edge that would start the next frame. No truncated frames.
  - IDLE outputs: SCK=0, WS=0, sd_out=0.
- SCK generation:
  - div_cnt counts 0 to CLK_DIV-1.
  - SCK toggles when div_cnt == CLK_DIV-1.
  - SCK period = 2*CLK_DIV clk cycles.
  - The first rising edge is CLK_DIV cycles after RUN entry.
- Falling-edge updates:
  - WS, sd_out and bit_cnt update only together with SCK falling (1 to 0) transitions, in the same clk edge.
  - The receiver samples on SCK rising edges.
- bit_cnt:
  - Range 0 to 2*SLOT_W-1.
  - Wraps to 0 at a falling edge; that edge is the frame start.
  - WS = (bit_cnt >= SLOT_W).
- Frame load at frame start:
  - Pops one pair into a 2*SLOT_W shift register as {left, zeros(SLOT_W-DATA_W), right, zeros(SLOT_W-DATA_W)}.
  - Shifted left once per falling edge.
  - If the FIFO is empty, all zeros are loaded and underrun is set.
- Bit output by mode:
  - Left-justified: sd_out = shift-register MSB, so the MSB is aligned with the WS edge.
  - I2S: sd_out = the previous bit, via a 1-bit delay register, so the MSB appears one SCK after the WS edge.
  - In I2S mode the right-slot last bit carries into the first SCK of the next frame.
  - On stop, that final delayed bit is not emitted.
- underrun:
  - Set has priority over underrun_clr in the same cycle.
  - Cleared only by underrun_clr or reset.
- Mode and enable:
  - mode changes while in RUN are ignored until the next IDLE to RUN entry.
  - enable re-asserted before the stop completes: running continues without a gap.

Test Plan:
- Reset mid-frame:
  - Stimulus: deassert reset during the right slot.
  - Required response: SCK, WS and sd_out all 0 immediately; fifo_level=0.
  - After release, re-enable and check the first frame is well-formed.
- Left-justified:
  - Setup: defaults, mode=1.
  - Stimulus: push 16'hA5C3 / 16'h0F01, enable.
  - Required response: SCK period of 4 clk.
  - Required response: WS=0 for 32 SCK, then 1 for 32 SCK.
  - Required response: left slot bits = A5C3 MSB-first then 16 zeros; right slot = 0F01 then zeros.
- I2S mode:
  - Stimulus: same data as the left-justified case, mode=0.
  - Required response: every bit is delayed one SCK relative to the left-justified case.
  - Required response: MSB of A5C3 is sampled on the 2nd rising edge after WS falls.
- Underrun:
  - Stimulus: push one pair, enable.
  - Required response: frame 2 is all zeros and underrun=1 at the start of frame 2.
  - Stimulus: underrun_clr for 1 cycle.
  - Required response: underrun=0.
  - Stimulus: clr coincident with a new underrun.
  - Required response: underrun stays 1.
- FIFO full/backpressure:
  - Stimulus: hold s_valid with 6 pairs while idle.
  - Required response: 4 accepted; fifo_level=4, s_ready=0.
  - Stimulus: after enable, let one frame start.
  - Required response: one pop; level=3 and s_ready=1; output order preserved.
- Graceful stop and parameter variation:
  - Stimulus: drop enable mid-frame.
  - Required response: the frame completes and busy falls at the frame boundary.
  - Stimulus: rerun with DATA_W=24, SLOT_W=24, CLK_DIV=1, mode=0.
  - Required response: the LSB of right carries into the next frame's first SCK.
